// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage ahead of decode. Holds the PC, drives the instruction-memory
//   request handshake and owns the IF/ID register (instr / pc / op / func).
//   A one-entry skid buffer catches a response that lands while decode is
//   stalled; a branch redirect flushes the slot and the buffer.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous, active-low reset
//   id_stall     decode cannot accept a new instruction
//   br_taken     one-cycle redirect pulse (highest priority)
//   br_target    redirect address, low two bits ignored
//   imem_req     fetch request valid          (decoded from state)
//   imem_addr    fetch address = pc           (decoded from pc register)
//   imem_rdata   instruction word from memory
//   imem_ready   response valid for imem_addr
//   if_valid     IF/ID slot holds a live instruction
//   if_instr     IF/ID instruction word (NOP when empty/flushed)
//   if_pc        address of if_instr
//   op / func    if_instr[31:26] / if_instr[5:0], registered with if_instr
//
// Configuration
//   IFETCH_PERF_CNT_EN : adds saturating perf_fetch_cnt / perf_stall_cnt.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [31:0]   NOP      = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_stall,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          imem_ready,
    output logic          if_valid,
    output logic [31:0]   if_instr,
    output logic [AW-1:0] if_pc,
    output logic [5:0]    op,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_stall_cnt,
`endif
    output logic [5:0]    func
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [31:0]   buf_instr_reg, buf_instr_next;
    logic [AW-1:0] buf_pc_reg, buf_pc_next;
    logic          if_valid_reg, if_valid_next;
    logic [31:0]   if_instr_reg, if_instr_next;
    logic [AW-1:0] if_pc_reg, if_pc_next;
    logic [5:0]    op_reg, op_next;
    logic [5:0]    func_reg, func_next;

    logic          slot_free;
    logic          ifid_write;
    logic [31:0]   wr_instr;
    logic [AW-1:0] wr_pc;

    assign slot_free = !if_valid_reg || !id_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        buf_instr_next = buf_instr_reg;
        buf_pc_next    = buf_pc_reg;
        if_valid_next  = if_valid_reg;
        if_instr_next  = if_instr_reg;
        if_pc_next     = if_pc_reg;
        op_next        = op_reg;
        func_next      = func_reg;
        ifid_write     = 1'b0;
        wr_instr       = imem_rdata;
        wr_pc          = pc_reg;

        case (state_reg)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    pc_next = pc_reg + AW'(4);
                    if (slot_free) begin
                        ifid_write = 1'b1;
                    end else begin
                        buf_instr_next = imem_rdata;
                        buf_pc_next    = pc_reg;
                        state_next     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    ifid_write = 1'b1;
                    wr_instr   = buf_instr_reg;
                    wr_pc      = buf_pc_reg;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase

        if (ifid_write) begin
            if_valid_next = 1'b1;
            if_instr_next = wr_instr;
            if_pc_next    = wr_pc;
            op_next       = wr_instr[31:26];
            func_next     = wr_instr[5:0];
        end else if (!id_stall) begin
            // decode took the instruction and nothing replaces it
            if_valid_next = 1'b0;
            if_instr_next = NOP;
            op_next       = NOP[31:26];
            func_next     = NOP[5:0];
        end

        // Redirect wins over everything, including a same-cycle response;
        // leaving HOLD is enough to discard the buffered word.
        if (br_taken) begin
            ifid_write    = 1'b0;
            state_next    = FETCH;
            pc_next       = br_target & ~AW'(3);
            if_valid_next = 1'b0;
            if_instr_next = NOP;
            op_next       = NOP[31:26];
            func_next     = NOP[5:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg        <= RESET_PC;
            buf_instr_reg <= NOP;
            buf_pc_reg    <= '0;
            if_valid_reg  <= 1'b0;
            if_instr_reg  <= NOP;
            if_pc_reg     <= '0;
            op_reg        <= 6'd0;
            func_reg      <= 6'd0;
        end else begin
            pc_reg        <= pc_next;
            buf_instr_reg <= buf_instr_next;
            buf_pc_reg    <= buf_pc_next;
            if_valid_reg  <= if_valid_next;
            if_instr_reg  <= if_instr_next;
            if_pc_reg     <= if_pc_next;
            op_reg        <= op_next;
            func_reg      <= func_next;
        end
    end

    assign imem_req  = (state_reg == FETCH);
    assign imem_addr = pc_reg;
    assign if_valid  = if_valid_reg;
    assign if_instr  = if_instr_reg;
    assign if_pc     = if_pc_reg;
    assign op        = op_reg;
    assign func      = func_reg;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg, stall_cnt_reg;
    logic        stall_cycle;

    assign stall_cycle = (imem_req && !imem_ready) || (state_reg == HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (ifid_write && fetch_cnt_reg != 32'hFFFF_FFFF)
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            if (stall_cycle && stall_cnt_reg != 32'hFFFF_FFFF)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_reg;
    assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule
